// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared constants and state encoding for the FIFO write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  // Default configuration of the arbiter.
  localparam int NREQ_DEF  = 4;
  localparam int DSIZE_DEF = 32;
  // Width of the running beat counter; it wraps 0xFFFF -> 0.
  localparam int CNT_W     = 16;

  // Arbiter state encoding.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Plain-vector aliases of the states, used by the state register.
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_XFER = XFER;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Returns the first asserted
//            bit of valid_i scanning upward from last_id_i+1, modulo NREQ.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  last_id_i,
  output logic [IDW-1:0]  winner_o,
  output logic            any_o
);

  logic [IDW-1:0] w_hi_win;
  logic [IDW-1:0] w_lo_win;
  logic           w_hi_any;

  // Lowest valid index above last_id, and lowest valid index overall as the
  // wrap-around fallback; scanning downward leaves the lowest match in place.
  always_comb begin
    w_hi_win = '0;
    w_lo_win = '0;
    w_hi_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        w_lo_win = IDW'(i);
        if (IDW'(i) > last_id_i) begin
          w_hi_win = IDW'(i);
          w_hi_any = 1'b1;
        end
      end
    end
  end

  assign winner_o = w_hi_any ? w_hi_win : w_lo_win;
  assign any_o    = |valid_i;

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter merging NREQ producer streams into the write
//            side of one shared FIFO. Write data and strobe are registered;
//            the FIFO full flag asserts one entry early to cover that stage.
// Options  : FIFO_ARB_PKT_LOCK_EN - when defined, a grant is held until the
//            beat carrying req_last; otherwise the grant is released after
//            every beat or whenever the granted producer is not valid.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DSIZE = DSIZE_DEF,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic [DSIZE-1:0]      fifo_wdata,
  output logic                  fifo_winc,
  input  logic                  fifo_wfull,
  output logic [IDW-1:0]        grant_id,
  output logic                  grant_vld,
  output logic [CNT_W-1:0]      beat_cnt
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]       state_q,   state_d;
  logic [IDW-1:0]   gid_q,     gid_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic             winc_q,    winc_d;
  logic [DSIZE-1:0] wdata_q,   wdata_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [DSIZE-1:0] w_data_arr [NREQ];
  logic [NREQ-1:0]  w_gid_oh;
  logic             w_xfer;
  logic             w_gid_valid;
  logic             w_beat;
  logic             w_release;
  logic [NREQ-1:0]  w_pick_valid;
  logic [IDW-1:0]   w_pick_ptr;
  logic [IDW-1:0]   w_pick_winner;
  logic             w_pick_any;

  // Unpack the flat producer data bus into one word per port.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_data_arr[g] = req_data[g*DSIZE +: DSIZE];
  end

  assign w_gid_oh    = NREQ'(1) << gid_q;
  assign w_xfer      = (state_q == ST_XFER);
  assign w_gid_valid = req_valid[gid_q];
  // The FIFO is written only when the granted producer is valid and the FIFO
  // has room; the early full flag leaves space for the registered write.
  assign w_beat      = w_xfer && w_gid_valid && !fifo_wfull;

`ifdef FIFO_ARB_PKT_LOCK_EN
  // Packet lock: keep the grant through valid gaps until the last word.
  assign w_release = w_beat && req_last[gid_q];
`else
  // Word-by-word: every beat, or a silent granted producer, frees the grant.
  assign w_release = w_beat || (w_xfer && !w_gid_valid);

  // Packet framing is not used in this build.
  logic w_unused_last;
  assign w_unused_last = ^req_last;
`endif

  // While transferring, the outgoing port is excluded so another valid port
  // takes over without a bubble; if none is valid the block drops to IDLE,
  // where the released port competes again on equal terms.
  assign w_pick_valid = w_xfer ? (req_valid & ~w_gid_oh) : req_valid;
  // A beat updates last_id this cycle, so scan from the beat source.
  assign w_pick_ptr   = w_beat ? gid_q : last_id_q;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .valid_i   (w_pick_valid),
    .last_id_i (w_pick_ptr),
    .winner_o  (w_pick_winner),
    .any_o     (w_pick_any)
  );

  // Next-state logic: arbitration, beat capture and grant hand-over.
  always_comb begin
    state_d   = state_q;
    gid_d     = gid_q;
    last_id_d = last_id_q;
    winc_d    = 1'b0;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (w_pick_any) begin
          state_d = ST_XFER;
          gid_d   = w_pick_winner;
        end
      end

      ST_XFER: begin
        if (w_beat) begin
          winc_d    = 1'b1;
          wdata_d   = w_data_arr[gid_q];
          last_id_d = gid_q;
          cnt_d     = cnt_q + CNT_W'(1);
        end
        if (w_release) begin
          if (w_pick_any) begin
            gid_d = w_pick_winner;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any packet in flight and points last_id
  // at the top port so the first arbitration favours port 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gid_q     <= '0;
      last_id_q <= IDW'(NREQ - 1);
      winc_q    <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gid_q     <= gid_d;
      last_id_q <= last_id_d;
      winc_q    <= winc_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready  = (w_xfer && !fifo_wfull) ? w_gid_oh : '0;
  assign fifo_wdata = wdata_q;
  assign fifo_winc  = winc_q;
  assign grant_id   = gid_q;
  assign grant_vld  = w_xfer;
  assign beat_cnt   = cnt_q;

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter with a write-side
//            scoreboard and per-scenario tasks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DSIZE = 32;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  fifo_winc;
  logic                  fifo_wfull;
  logic [IDW-1:0]        grant_id;
  logic                  grant_vld;
  logic [15:0]           beat_cnt;

  logic [DSIZE-1:0] tb_data [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_data[g*DSIZE +: DSIZE] = tb_data[g];
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_wr_arbiter #(
    .NREQ  (NREQ),
    .DSIZE (DSIZE),
    .IDW   (IDW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wdata (fifo_wdata),
    .fifo_winc  (fifo_winc),
    .fifo_wfull (fifo_wfull),
    .grant_id   (grant_id),
    .grant_vld  (grant_vld),
    .beat_cnt   (beat_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Producer model: words remaining, sequence number, position in packet.
  int prem [NREQ];
  int pseq [NREQ];
  int ppos [NREQ];
  int plen [NREQ];

  logic [DSIZE-1:0] exp_q [$];
  int               wr_cyc [$];
  int               exp_cnt;

  function automatic logic [DSIZE-1:0] word_of(int port, int seq);
    return {port[7:0], seq[23:0]};
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (prem[i] > 0);
      tb_data[i]   = word_of(i, pseq[i]);
      req_last[i]  = (ppos[i] == plen[i] - 1);
    end
  endtask

  task automatic load(int port, int n, int len);
    prem[port] = n;
    pseq[port] = 0;
    ppos[port] = 0;
    plen[port] = len;
  endtask

  task automatic expect_word(int port, int seq);
    exp_q.push_back(word_of(port, seq));
    exp_cnt++;
  endtask

  function automatic bit producers_busy();
    for (int i = 0; i < NREQ; i++) if (prem[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: scoreboard the write side at the falling edge, then advance
  // the producers that handshook at the rising edge.
  task automatic step();
    logic [NREQ-1:0]  hs;
    logic [DSIZE-1:0] exp_w;
    @(negedge clk);
    if (fifo_winc === 1'b1) begin
      wr_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_write: got %h, required no write", fifo_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if (fifo_wdata !== exp_w)
          $display("FAIL sb_word: got %h, required %h", fifo_wdata, exp_w);
        else
          n_pass++;
      end
    end
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        prem[i]--;
        pseq[i]++;
        ppos[i] = (ppos[i] + 1 == plen[i]) ? 0 : ppos[i] + 1;
      end
    end
    drive();
  endtask

  task automatic drain(int budget);
    int k = 0;
    while ((exp_q.size() != 0 || producers_busy()) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0 within %0d cycles",
               exp_q.size(), budget);
    end
    step();
    step();
  endtask

  task automatic clear_producers();
    for (int i = 0; i < NREQ; i++) load(i, 0, 1);
    drive();
    exp_q.delete();
    wr_cyc.delete();
    exp_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    fifo_wfull = 1'b0;
    clear_producers();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    fifo_wfull = 1'b0;
    clear_producers();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) load(i, 1, 1);
    drive();
    @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b, required 0000", req_ready);
    else n_pass++;
    n_checks++;
    if (fifo_winc !== 1'b0) $display("FAIL reset_winc: got %b, required 0", fifo_winc);
    else n_pass++;
    n_checks++;
    if (fifo_wdata !== 32'h0) $display("FAIL reset_wdata: got %h, required 0", fifo_wdata);
    else n_pass++;
    n_checks++;
    if (grant_vld !== 1'b0 || grant_id !== 2'd0)
      $display("FAIL reset_grant: got vld=%b id=%0d, required vld=0 id=0", grant_vld, grant_id);
    else n_pass++;
    n_checks++;
    if (beat_cnt !== 16'd0) $display("FAIL reset_beat_cnt: got %0d, required 0", beat_cnt);
    else n_pass++;
    clear_producers();
    #1 rst_n = 1'b1;
    step();
    n_checks++;
    if (grant_vld !== 1'b0) $display("FAIL idle_no_req: got grant_vld=%b, required 0", grant_vld);
    else n_pass++;
  endtask

  task automatic test_two_ports();
    do_reset();
    load(0, 1, 1);
    load(2, 1, 1);
    drive();
    expect_word(0, 0);
    expect_word(2, 0);
    step();
    n_checks++;
    if (grant_vld !== 1'b1 || grant_id !== 2'd0)
      $display("FAIL two_first_grant: got vld=%b id=%0d, required vld=1 id=0", grant_vld, grant_id);
    else n_pass++;
    step();
    n_checks++;
    if (grant_vld !== 1'b1 || grant_id !== 2'd2)
      $display("FAIL two_second_grant: got vld=%b id=%0d, required vld=1 id=2", grant_vld, grant_id);
    else n_pass++;
    drain(20);
    n_checks++;
    if (wr_cyc.size() != 2 || wr_cyc[1] - wr_cyc[0] != 1)
      $display("FAIL two_consecutive_winc: got %0d writes, required 2 on adjacent cycles", wr_cyc.size());
    else n_pass++;
    n_checks++;
    if (beat_cnt !== 16'(exp_cnt)) $display("FAIL two_beat_cnt: got %0d, required %0d", beat_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < NREQ; p++) load(p, 2, 1);
    drive();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NREQ; p++) expect_word(p, r);
    drain(40);
    n_checks++;
    if (wr_cyc.size() != 8 || wr_cyc[7] - wr_cyc[0] != 7)
      $display("FAIL rr_no_bubble: got %0d writes, required 8 on consecutive cycles", wr_cyc.size());
    else n_pass++;
    n_checks++;
    if (beat_cnt !== 16'(exp_cnt)) $display("FAIL rr_beat_cnt: got %0d, required %0d", beat_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_packet();
    do_reset();
    load(1, 3, 3);
    load(2, 1, 1);
    drive();
`ifdef FIFO_ARB_PKT_LOCK_EN
    expect_word(1, 0);
    expect_word(1, 1);
    expect_word(1, 2);
    expect_word(2, 0);
`else
    expect_word(1, 0);
    expect_word(2, 0);
    expect_word(1, 1);
    expect_word(1, 2);
`endif
    step();
    step();
    n_checks++;
`ifdef FIFO_ARB_PKT_LOCK_EN
    if (grant_id !== 2'd1) $display("FAIL pkt_hold_grant: got id=%0d, required 1", grant_id);
    else n_pass++;
`else
    if (grant_id !== 2'd2) $display("FAIL pkt_release_grant: got id=%0d, required 2", grant_id);
    else n_pass++;
`endif
    drain(30);
    n_checks++;
    if (beat_cnt !== 16'(exp_cnt)) $display("FAIL pkt_beat_cnt: got %0d, required %0d", beat_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_wfull();
    logic [IDW-1:0] g0;
    do_reset();
    load(0, 6, 1);
    load(1, 6, 1);
    drive();
    for (int s = 0; s < 6; s++) begin
      expect_word(0, s);
      expect_word(1, s);
    end
    repeat (3) step();
    fifo_wfull = 1'b1;
    g0 = grant_id;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL full_ready_now: got %b, required 0000", req_ready);
    else n_pass++;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (fifo_winc !== 1'b0 || req_ready !== 4'b0000 || grant_id !== g0 || grant_vld !== 1'b1)
        $display("FAIL full_hold: cycle %0d got winc=%b ready=%b id=%0d vld=%b, required winc=0 ready=0000 id=%0d vld=1",
                 c, fifo_winc, req_ready, grant_id, grant_vld, g0);
      else n_pass++;
    end
    fifo_wfull = 1'b0;
    drain(60);
    n_checks++;
    if (beat_cnt !== 16'(exp_cnt)) $display("FAIL full_beat_cnt: got %0d, required %0d", beat_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    load(1, 4, 4);
    drive();
    expect_word(1, 0);
    repeat (3) step();
    n_checks++;
    if (grant_vld !== 1'b1 || grant_id !== 2'd1)
      $display("FAIL mid_pre_grant: got vld=%b id=%0d, required vld=1 id=1", grant_vld, grant_id);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || fifo_winc !== 1'b0 || fifo_wdata !== 32'h0)
      $display("FAIL mid_rst_write: got ready=%b winc=%b wdata=%h, required 0000/0/0",
               req_ready, fifo_winc, fifo_wdata);
    else n_pass++;
    n_checks++;
    if (grant_vld !== 1'b0 || grant_id !== 2'd0 || beat_cnt !== 16'd0)
      $display("FAIL mid_rst_grant: got vld=%b id=%0d cnt=%0d, required 0/0/0",
               grant_vld, grant_id, beat_cnt);
    else n_pass++;
    clear_producers();
    @(posedge clk);
    #1 rst_n = 1'b1;
    load(1, 1, 1);
    load(3, 1, 1);
    load(0, 1, 1);
    drive();
    expect_word(0, 0);
    expect_word(1, 0);
    expect_word(3, 0);
    step();
    n_checks++;
    if (grant_vld !== 1'b1 || grant_id !== 2'd0)
      $display("FAIL mid_first_grant: got vld=%b id=%0d, required vld=1 id=0", grant_vld, grant_id);
    else n_pass++;
    drain(30);
    n_checks++;
    if (beat_cnt !== 16'(exp_cnt)) $display("FAIL mid_beat_cnt: got %0d, required %0d", beat_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    load(0, 32768, 1);
    load(1, 32767, 1);
    drive();
    for (int k = 0; k < 65535; k++) expect_word(k % 2, k / 2);
    drain(70000);
    n_checks++;
    if (beat_cnt !== 16'hFFFF) $display("FAIL wrap_preload: got %h, required ffff", beat_cnt);
    else n_pass++;
    load(2, 1, 1);
    drive();
    expect_word(2, 0);
    drain(20);
    n_checks++;
    if (beat_cnt !== 16'h0000) $display("FAIL wrap_to_zero: got %h, required 0000", beat_cnt);
    else n_pass++;
  endtask

  initial begin
    rst_n      = 1'b1;
    fifo_wfull = 1'b0;
    exp_cnt    = 0;
    for (int i = 0; i < NREQ; i++) load(i, 0, 1);
    drive();
    test_reset();
    test_two_ports();
    test_round_robin();
    test_packet();
    test_wfull();
    test_reset_mid_packet();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
